rvfi_order_reorder: RTL and testbench

Reorders out-of-order RVFI retirement records into strict `rvfi_order` sequence and presents them as a single in-order RVFI channel. Sits between a core's out-of-order retirement port and the RVFI checkers and cover counters, which require monotonically increasing order on their inputs. Bounded window buffer with sticky protocol-error reporting. No backpressure: the downstream checkers consume every cycle.

---
 rtl/rvfi_order_reorder_pkg.sv | 21 ++
 rtl/rvfi_order_reorder_if.sv | 36 +++
 rtl/rvfi_order_reorder_store.sv | 35 +++
 rtl/rvfi_order_reorder.sv | 89 ++++++++
 tb/tb_rvfi_order_reorder.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvfi_order_reorder_pkg.sv
// rvfi_reorder_pkg: shared payload record and error-cause encoding for the RVFI reorder buffer.
//   RVFI_XLEN    : width of pc/rd data fields held in a record
//   rvfi_rec_t   : payload stored per window slot (order is implied by slot position)
//   reorder_err_e: first protocol-error cause reported on err_code
package rvfi_reorder_pkg;
   localparam int RVFI_XLEN = 32;
   typedef struct packed {
      logic [31:0]          insn;
      logic                 trap;
      logic                 intr;
      logic [RVFI_XLEN-1:0] pc_rdata;
      logic [RVFI_XLEN-1:0] pc_wdata;
      logic [4:0]           rd_addr;
      logic [RVFI_XLEN-1:0] rd_wdata;
   } rvfi_rec_t;
   typedef enum logic [1:0] {
      NONE   = 2'd0,
      STALE  = 2'd1,
      WINDOW = 2'd2
   } reorder_err_e;
endpackage

// File: rtl/rvfi_order_reorder_if.sv
// rvfi_order_reorder_if: retirement input channel, in-order output channel and status of the reorder buffer.
//   master: the retiring core side (drives in_*, observes out_*, occupancy, err, err_code)
//   slave : the reorder buffer itself
interface rvfi_order_reorder_if #(parameter int DEPTH = 8, parameter int XLEN = 32);
   logic                   in_valid;
   logic [63:0]            in_order;
   logic [31:0]            in_insn;
   logic                   in_trap;
   logic                   in_intr;
   logic [XLEN-1:0]        in_pc_rdata;
   logic [XLEN-1:0]        in_pc_wdata;
   logic [4:0]             in_rd_addr;
   logic [XLEN-1:0]        in_rd_wdata;
   logic                   out_valid;
   logic [63:0]            out_order;
   logic [31:0]            out_insn;
   logic                   out_trap;
   logic                   out_intr;
   logic [XLEN-1:0]        out_pc_rdata;
   logic [XLEN-1:0]        out_pc_wdata;
   logic [4:0]             out_rd_addr;
   logic [XLEN-1:0]        out_rd_wdata;
   logic [$clog2(DEPTH):0] occupancy;
   logic                   err;
   logic [1:0]             err_code;
   modport master (
      output in_valid, in_order, in_insn, in_trap, in_intr, in_pc_rdata, in_pc_wdata, in_rd_addr, in_rd_wdata,
      input  out_valid, out_order, out_insn, out_trap, out_intr, out_pc_rdata, out_pc_wdata, out_rd_addr,
             out_rd_wdata, occupancy, err, err_code
   );
   modport slave (
      input  in_valid, in_order, in_insn, in_trap, in_intr, in_pc_rdata, in_pc_wdata, in_rd_addr, in_rd_wdata,
      output out_valid, out_order, out_insn, out_trap, out_intr, out_pc_rdata, out_pc_wdata, out_rd_addr,
             out_rd_wdata, occupancy, err, err_code
   );
endinterface

// File: rtl/rvfi_order_reorder_store.sv
// rvfi_reorder_store: window slot storage, one write port and one read-and-clear port.
//   clock/resetn : clock, async active-low reset (clears valid bitmap only)
//   we/waddr/wdata: write a record and mark its slot valid
//   rclr/raddr    : clear the slot at raddr; rdata shows its payload combinationally
//   valid         : full valid bitmap, for duplicate detection at any index
module rvfi_reorder_store
   import rvfi_reorder_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  rvfi_rec_t        wdata,
   input  logic             rclr,
   input  logic [AW-1:0]    raddr,
   output rvfi_rec_t        rdata,
   output logic [DEPTH-1:0] valid
);
   rvfi_rec_t mem [DEPTH];
   // A write never targets a valid slot and a clear only targets a valid one, so they cannot collide.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) valid <= '0;
      else begin
         if (we) valid[waddr] <= 1'b1;
         if (rclr) valid[raddr] <= 1'b0;
      end
   end
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end
   assign rdata = mem[raddr];
endmodule

// File: rtl/rvfi_order_reorder.sv
// rvfi_order_reorder: reorders out-of-order RVFI retirements into strict rvfi_order sequence.
//   clock/resetn: clock, async active-low reset
//   bus (slave) : in_* retirement records, registered in-order out_* records,
//                 occupancy, sticky err with first-cause err_code
module rvfi_order_reorder
   import rvfi_reorder_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32
) (
   input logic                clock,
   input logic                resetn,
   rvfi_order_reorder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   logic [63:0]      next_order;
   logic [63:0]      delta;
   logic [DEPTH-1:0] valid;
   logic [AW-1:0]    head;
   logic             stale;
   logic             window;
   logic             accept;
   logic             drain;
   rvfi_rec_t        wdata;
   rvfi_rec_t        rdata;
   // All checks use pre-edge state; a negative wrapped delta means the order was already retired.
   always_comb begin
      head            = next_order[AW-1:0];
      delta           = bus.in_order - next_order;
      stale           = delta[63] | valid[bus.in_order[AW-1:0]];
      window          = delta >= 64'(DEPTH);
      accept          = bus.in_valid & ~stale & ~window;
      drain           = valid[head];
      wdata.insn      = bus.in_insn;
      wdata.trap      = bus.in_trap;
      wdata.intr      = bus.in_intr;
      wdata.pc_rdata  = bus.in_pc_rdata;
      wdata.pc_wdata  = bus.in_pc_wdata;
      wdata.rd_addr   = bus.in_rd_addr;
      wdata.rd_wdata  = bus.in_rd_wdata;
   end
   rvfi_reorder_store #(.DEPTH(DEPTH)) u_store (
      .clock (clock),
      .resetn(resetn),
      .we    (accept),
      .waddr (bus.in_order[AW-1:0]),
      .wdata (wdata),
      .rclr  (drain),
      .raddr (head),
      .rdata (rdata),
      .valid (valid)
   );
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         next_order       <= '0;
         bus.out_valid    <= 1'b0;
         bus.out_order    <= '0;
         bus.out_insn     <= '0;
         bus.out_trap     <= 1'b0;
         bus.out_intr     <= 1'b0;
         bus.out_pc_rdata <= '0;
         bus.out_pc_wdata <= '0;
         bus.out_rd_addr  <= '0;
         bus.out_rd_wdata <= '0;
         bus.occupancy    <= '0;
         bus.err          <= 1'b0;
         bus.err_code     <= NONE;
      end else begin
         bus.out_valid <= drain;
         bus.occupancy <= bus.occupancy + OW'(accept) - OW'(drain);
         if (drain) begin
            bus.out_order    <= next_order;
            bus.out_insn     <= rdata.insn;
            bus.out_trap     <= rdata.trap;
            bus.out_intr     <= rdata.intr;
            bus.out_pc_rdata <= rdata.pc_rdata;
            bus.out_pc_wdata <= rdata.pc_wdata;
            bus.out_rd_addr  <= rdata.rd_addr;
            bus.out_rd_wdata <= rdata.rd_wdata;
            next_order       <= next_order + 64'd1;
         end
         if (bus.in_valid && (stale || window)) begin
            bus.err <= 1'b1;
            if (!bus.err) bus.err_code <= stale ? STALE : WINDOW;
         end
      end
   end
endmodule

// File: tb/tb_rvfi_order_reorder.sv
// tb_rvfi_order_reorder: randomized self-checking bench against a queue-based reference model.
module tb_rvfi_order_reorder;
   import rvfi_reorder_pkg::*;
   localparam int DEPTH = 8;
   localparam int OW    = $clog2(DEPTH) + 1;
   logic clock;
   logic resetn;
   int   n_cmp;
   int   n_bad;
   rvfi_order_reorder_if #(.DEPTH(DEPTH), .XLEN(32)) bus ();
   rvfi_order_reorder #(.DEPTH(DEPTH), .XLEN(32)) dut (.clock(clock), .resetn(resetn), .bus(bus));
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // reference model: pending records keyed by their order number
   rvfi_rec_t       pend [longint unsigned];
   longint unsigned m_next;
   bit              exp_valid;
   longint unsigned exp_order;
   rvfi_rec_t       exp_rec;
   int              exp_occ;
   bit              exp_err;
   logic [1:0]      exp_code;

   task automatic model_clear;
      pend.delete();
      m_next    = 0;
      exp_valid = 0;
      exp_order = 0;
      exp_rec   = '0;
      exp_occ   = 0;
      exp_err   = 0;
      exp_code  = 2'd0;
   endtask

   task automatic cycle(input bit v, input longint unsigned ord);
      rvfi_rec_t r;
      bit        drn;
      bit        clash;
      r.insn     = $urandom;
      r.trap     = 1'($urandom_range(0, 1));
      r.intr     = 1'($urandom_range(0, 1));
      r.pc_rdata = $urandom;
      r.pc_wdata = $urandom;
      r.rd_addr  = 5'($urandom);
      r.rd_wdata = $urandom;
      bus.in_valid    = v;
      bus.in_order    = ord;
      bus.in_insn     = r.insn;
      bus.in_trap     = r.trap;
      bus.in_intr     = r.intr;
      bus.in_pc_rdata = r.pc_rdata;
      bus.in_pc_wdata = r.pc_wdata;
      bus.in_rd_addr  = r.rd_addr;
      bus.in_rd_wdata = r.rd_wdata;
      @(posedge clock);
      drn = pend.exists(m_next);
      if (v) begin
         clash = 0;
         foreach (pend[k]) if ((k % DEPTH) == (ord % DEPTH)) clash = 1;
         if ($signed(ord - m_next) < 0 || clash) begin
            if (!exp_err) exp_code = 2'd1;
            exp_err = 1;
         end else if (ord - m_next >= DEPTH) begin
            if (!exp_err) exp_code = 2'd2;
            exp_err = 1;
         end else pend[ord] = r;
      end
      exp_valid = drn;
      if (drn) begin
         exp_rec   = pend[m_next];
         exp_order = m_next;
         pend.delete(m_next);
         m_next++;
      end
      exp_occ = pend.num();
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic do_reset;
      bus.in_valid = 1'b0;
      resetn = 1'b0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
      model_clear();
   endtask

   task automatic test_reset;
      bus.in_valid = 1'b0;
      bus.in_order = '0;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      #1;
      n_cmp++;
      if ({bus.out_valid, bus.out_order, bus.out_insn, bus.out_trap, bus.out_intr, bus.out_pc_rdata,
           bus.out_pc_wdata, bus.out_rd_addr, bus.out_rd_wdata, bus.occupancy, bus.err, bus.err_code} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got v=%0b ord=%0d insn=%h occ=%0d err=%0b code=%0d, want all zero",
                  bus.out_valid, bus.out_order, bus.out_insn, bus.occupancy, bus.err, bus.err_code);
      end
      @(posedge clock);
      #1 resetn = 1'b1;
      model_clear();
   endtask

   task automatic test_in_order;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(i < 4, longint'(i));
         n_cmp++;
         if (bus.out_valid !== exp_valid || (exp_valid && bus.out_order !== exp_order) ||
             bus.occupancy !== OW'(exp_occ) || bus.occupancy > 1 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL in_order step %0d: got v=%0b ord=%0d occ=%0d err=%0b, want v=%0b ord=%0d occ=%0d err=0",
                     i, bus.out_valid, bus.out_order, bus.occupancy, bus.err, exp_valid, exp_order, exp_occ);
         end
      end
   endtask

   task automatic test_permutation;
      int seq [8] = '{3, 1, 0, 2, -1, -1, -1, -1};
      int peak = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(seq[i] >= 0, seq[i] >= 0 ? longint'(seq[i]) : 0);
         if (int'(bus.occupancy) > peak) peak = int'(bus.occupancy);
         n_cmp++;
         if (bus.out_valid !== exp_valid || (exp_valid && bus.out_order !== exp_order) ||
             bus.occupancy !== OW'(exp_occ)) begin
            n_bad++;
            $display("FAIL permutation step %0d: got v=%0b ord=%0d occ=%0d, want v=%0b ord=%0d occ=%0d",
                     i, bus.out_valid, bus.out_order, bus.occupancy, exp_valid, exp_order, exp_occ);
         end
      end
      n_cmp++;
      if (peak != 3 || bus.occupancy !== '0) begin
         n_bad++;
         $display("FAIL permutation_peak: got peak=%0d final=%0d, want peak=3 final=0", peak, bus.occupancy);
      end
   endtask

   task automatic test_window;
      do_reset();
      cycle(1, DEPTH - 1);
      n_cmp++;
      if (bus.err !== 1'b0 || bus.occupancy !== OW'(1) || bus.occupancy !== OW'(exp_occ)) begin
         n_bad++;
         $display("FAIL window_edge_accept: got err=%0b occ=%0d, want err=0 occ=1", bus.err, bus.occupancy);
      end
      cycle(1, DEPTH);
      n_cmp++;
      if (bus.err !== 1'b1 || bus.err_code !== 2'd2 || bus.occupancy !== OW'(1) ||
          bus.err_code !== exp_code || bus.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL window_reject: got err=%0b code=%0d occ=%0d v=%0b, want err=1 code=2 occ=1 v=0",
                  bus.err, bus.err_code, bus.occupancy, bus.out_valid);
      end
   endtask

   task automatic test_dup_stale;
      do_reset();
      cycle(1, 5);
      cycle(1, 5);
      n_cmp++;
      if (bus.err !== 1'b1 || bus.err_code !== 2'd1 || bus.occupancy !== OW'(1)) begin
         n_bad++;
         $display("FAIL duplicate: got err=%0b code=%0d occ=%0d, want err=1 code=1 occ=1",
                  bus.err, bus.err_code, bus.occupancy);
      end
      for (int i = 0; i < 9; i++) begin
         cycle(i < 5, longint'(i));
         n_cmp++;
         if (bus.out_valid !== exp_valid || (exp_valid && bus.out_order !== exp_order) ||
             bus.occupancy !== OW'(exp_occ)) begin
            n_bad++;
            $display("FAIL dup_drain step %0d: got v=%0b ord=%0d occ=%0d, want v=%0b ord=%0d occ=%0d",
                     i, bus.out_valid, bus.out_order, bus.occupancy, exp_valid, exp_order, exp_occ);
         end
      end
      cycle(1, 2);
      n_cmp++;
      if (bus.err !== 1'b1 || bus.err_code !== 2'd1 || bus.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL stale: got err=%0b code=%0d v=%0b, want err=1 code=1 v=0", bus.err, bus.err_code, bus.out_valid);
      end
      cycle(1, m_next + 20);
      n_cmp++;
      if (bus.err_code !== 2'd1 || bus.err_code !== exp_code) begin
         n_bad++;
         $display("FAIL code_sticky: got code=%0d, want code=1", bus.err_code);
      end
   endtask

   task automatic test_simultaneous;
      do_reset();
      cycle(1, 1);
      cycle(1, 0);
      n_cmp++;
      if (bus.occupancy !== OW'(2) || bus.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL simul_setup: got occ=%0d v=%0b, want occ=2 v=0", bus.occupancy, bus.out_valid);
      end
      cycle(1, 2);
      n_cmp++;
      if (bus.occupancy !== OW'(2) || bus.out_valid !== 1'b1 || bus.out_order !== 64'd0 ||
          bus.out_insn !== exp_rec.insn || bus.err !== 1'b0) begin
         n_bad++;
         $display("FAIL simul_accept_drain: got occ=%0d v=%0b ord=%0d insn=%h err=%0b, want occ=2 v=1 ord=0 insn=%h err=0",
                  bus.occupancy, bus.out_valid, bus.out_order, bus.out_insn, bus.err, exp_rec.insn);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0);
         n_cmp++;
         if (bus.out_valid !== exp_valid || (exp_valid && bus.out_order !== exp_order) ||
             bus.occupancy !== OW'(exp_occ)) begin
            n_bad++;
            $display("FAIL simul_drain step %0d: got v=%0b ord=%0d occ=%0d, want v=%0b ord=%0d occ=%0d",
                     i, bus.out_valid, bus.out_order, bus.occupancy, exp_valid, exp_order, exp_occ);
         end
      end
   endtask

   task automatic test_async_reset;
      do_reset();
      for (int i = 1; i <= 4; i++) cycle(1, longint'(i));
      cycle(1, 0);
      cycle(0, 0);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_order !== 64'd0 || bus.occupancy !== OW'(4)) begin
         n_bad++;
         $display("FAIL areset_setup: got v=%0b ord=%0d occ=%0d, want v=1 ord=0 occ=4",
                  bus.out_valid, bus.out_order, bus.occupancy);
      end
      #2 resetn = 1'b0;
      #1;
      n_cmp++;
      if ({bus.out_valid, bus.out_order, bus.out_insn, bus.out_pc_rdata, bus.out_rd_wdata, bus.occupancy,
           bus.err, bus.err_code} !== '0) begin
         n_bad++;
         $display("FAIL areset_immediate: got v=%0b ord=%0d insn=%h occ=%0d err=%0b, want all zero",
                  bus.out_valid, bus.out_order, bus.out_insn, bus.occupancy, bus.err);
      end
      @(posedge clock);
      #1 resetn = 1'b1;
      model_clear();
      for (int i = 0; i < 10; i++) begin
         cycle(i == 0 || i == 4, i == 0 ? 1 : 0);
         n_cmp++;
         if (bus.out_valid !== exp_valid || (exp_valid && bus.out_order !== exp_order) ||
             bus.occupancy !== OW'(exp_occ)) begin
            n_bad++;
            $display("FAIL areset_after step %0d: got v=%0b ord=%0d occ=%0d, want v=%0b ord=%0d occ=%0d",
                     i, bus.out_valid, bus.out_order, bus.occupancy, exp_valid, exp_order, exp_occ);
         end
      end
   endtask

   task automatic test_random;
      int              r;
      longint unsigned ord;
      for (int i = 0; i < 600; i++) begin
         if (i % 150 == 0) do_reset();
         r = $urandom_range(0, 19);
         if (r == 0 && m_next > 0) ord = m_next - 1;
         else if (r == 1) ord = m_next + DEPTH + $urandom_range(0, 3);
         else ord = m_next + $urandom_range(0, DEPTH - 1);
         cycle($urandom_range(0, 3) != 0, ord);
         n_cmp++;
         if (bus.out_valid !== exp_valid || bus.occupancy !== OW'(exp_occ) || bus.err !== exp_err ||
             bus.err_code !== exp_code) begin
            n_bad++;
            $display("FAIL random_status cyc %0d: got v=%0b occ=%0d err=%0b code=%0d, want v=%0b occ=%0d err=%0b code=%0d",
                     i, bus.out_valid, bus.occupancy, bus.err, bus.err_code, exp_valid, exp_occ, exp_err, exp_code);
         end
         if (exp_valid) begin
            n_cmp++;
            if (bus.out_order !== exp_order || bus.out_insn !== exp_rec.insn || bus.out_trap !== exp_rec.trap ||
                bus.out_intr !== exp_rec.intr || bus.out_pc_rdata !== exp_rec.pc_rdata ||
                bus.out_pc_wdata !== exp_rec.pc_wdata || bus.out_rd_addr !== exp_rec.rd_addr ||
                bus.out_rd_wdata !== exp_rec.rd_wdata) begin
               n_bad++;
               $display("FAIL random_payload cyc %0d: got ord=%0d insn=%h pc=%h/%h rd=%0d:%h, want ord=%0d insn=%h pc=%h/%h rd=%0d:%h",
                        i, bus.out_order, bus.out_insn, bus.out_pc_rdata, bus.out_pc_wdata, bus.out_rd_addr,
                        bus.out_rd_wdata, exp_order, exp_rec.insn, exp_rec.pc_rdata, exp_rec.pc_wdata,
                        exp_rec.rd_addr, exp_rec.rd_wdata);
            end
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_in_order();
      test_permutation();
      test_window();
      test_dup_stale();
      test_simultaneous();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
